// File: rtl/elevator_ctrl.sv
// elevator_ctrl: single-car, four-floor elevator sequencer.
// It fetches one request from an external buffer, decodes the target floor,
// travels floor by floor, holds the door open, then returns to IDLE.
module elevator_ctrl #(
  parameter int FLOOR_TICKS = 4,  // cycles per floor travelled, 1..255
  parameter int DOOR_TICKS  = 3   // cycles door held open, 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       q_empty,
  input  logic [2:0] req,
  output logic       done,
  output logic [2:0] floor,
  output logic       moving,
  output logic       dir_up,
  output logic       door_open,
  output logic       busy
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_MOVE, S_DOOR} state_t;

  localparam logic [7:0] FLOOR_LAST = 8'(FLOOR_TICKS - 1);
  localparam logic [7:0] DOOR_LAST  = 8'(DOOR_TICKS - 1);

  state_t     state;
  logic [2:0] target;
  logic [7:0] cnt;
  logic [2:0] dec;
  logic [2:0] step;

  // Request code to target floor; 0 means the code carries no valid target.
  function automatic logic [2:0] decode(input logic [2:0] code);
    case (code)
      3'b001:  decode = 3'd1;
      3'b010:  decode = 3'd2;
      3'b011:  decode = 3'd3;
      3'b110:  decode = 3'd2;
      3'b111:  decode = 3'd3;
      3'b100:  decode = 3'd4;
      default: decode = 3'd0;
    endcase
  endfunction

  assign dec = decode(req);

  // Floor one step in the current direction, clamped so it never leaves 1..4.
  assign step = dir_up ? ((floor == 3'd4) ? 3'd4 : floor + 3'd1)
                       : ((floor == 3'd1) ? 3'd1 : floor - 3'd1);

  // Outputs are pure decodes of the registered state.
  assign done      = (state == S_REQ);
  assign moving    = (state == S_MOVE);
  assign door_open = (state == S_DOOR);
  assign busy      = (state != S_IDLE);

  // Sequencer: state, floor position, direction, target and tick counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      floor  <= 3'd1;
      dir_up <= 1'b1;
      target <= 3'd1;
      cnt    <= 8'd0;
    end else begin
      case (state)
        S_IDLE: if (!q_empty) state <= S_REQ;
        S_REQ:  state <= S_WAIT;
        S_WAIT: begin
          cnt <= 8'd0;
          if (dec == 3'd0) begin
            state <= S_IDLE;
          end else begin
            target <= dec;
            if (dec == floor) begin
              state <= S_DOOR;
            end else begin
              dir_up <= (dec > floor);
              state  <= S_MOVE;
            end
          end
        end
        S_MOVE: begin
          if (cnt == FLOOR_LAST) begin
            cnt   <= 8'd0;
            floor <= step;
            if (step == target) state <= S_DOOR;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DOOR: begin
          if (cnt == DOOR_LAST) begin
            cnt   <= 8'd0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: directed vector table plus hand-written trips for elevator_ctrl.
module tb_elevator_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       q_empty;
  logic [2:0] req;
  logic       done;
  logic [2:0] floor;
  logic       moving;
  logic       dir_up;
  logic       door_open;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  elevator_ctrl #(.FLOOR_TICKS(4), .DOOR_TICKS(3)) dut (
    .clk(clk), .rst(rst), .q_empty(q_empty), .req(req),
    .done(done), .floor(floor), .moving(moving), .dir_up(dir_up),
    .door_open(door_open), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       q_empty;
    logic [2:0] req;
    logic [7:0] exp;
  } vec_t;

  // Packed expected outputs: {done, floor[2:0], moving, dir_up, door_open, busy}
  function automatic logic [7:0] pk(input logic d, input int f, input logic m,
                                    input logic u, input logic o, input logic b);
    pk = {d, 3'(f), m, u, o, b};
  endfunction

  // Drive inputs, clock once, compare outputs 1 time unit after the edge.
  task automatic step(input logic r, input logic qe, input logic [2:0] rq,
                      input logic [7:0] exp, input string name);
    logic [7:0] act;
    rst = r; q_empty = qe; req = rq;
    @(posedge clk);
    #1;
    act = {done, floor, moving, dir_up, door_open, busy};
    n_checks++;
    if (act !== exp || (moving && door_open)) begin
      n_fail++;
      $display("FAIL %s: got done/floor/mv/up/door/busy=%b/%0d/%b/%b/%b/%b expected %b/%0d/%b/%b/%b/%b",
               name, act[7], act[6:4], act[3], act[2], act[1], act[0],
               exp[7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  vec_t tbl[16];

  initial begin
    rst = 1'b1; q_empty = 1'b1; req = 3'b000;
    #1;

    // Reset, a dropped 000 request, a same-floor request, a dropped 101 request.
    tbl[0]  = '{1'b1, 1'b1, 3'b000, pk(0,1,0,1,0,0)};  // reset
    tbl[1]  = '{1'b1, 1'b0, 3'b100, pk(0,1,0,1,0,0)};  // reset held, inputs ignored
    tbl[2]  = '{1'b0, 1'b1, 3'b000, pk(0,1,0,1,0,0)};  // idle, empty buffer
    tbl[3]  = '{1'b0, 1'b0, 3'b000, pk(1,1,0,1,0,1)};  // REQ, done pulse
    tbl[4]  = '{1'b0, 1'b0, 3'b000, pk(0,1,0,1,0,1)};  // WAIT
    tbl[5]  = '{1'b0, 1'b0, 3'b000, pk(0,1,0,1,0,0)};  // 000 -> IDLE one cycle
    tbl[6]  = '{1'b0, 1'b0, 3'b000, pk(1,1,0,1,0,1)};  // REQ again, two low cycles between pulses
    tbl[7]  = '{1'b0, 1'b0, 3'b000, pk(0,1,0,1,0,1)};  // WAIT
    tbl[8]  = '{1'b0, 1'b0, 3'b001, pk(0,1,0,1,1,1)};  // target==floor -> DOOR directly
    tbl[9]  = '{1'b0, 1'b0, 3'b001, pk(0,1,0,1,1,1)};  // DOOR 2, req ignored
    tbl[10] = '{1'b0, 1'b0, 3'b000, pk(0,1,0,1,1,1)};  // DOOR 3
    tbl[11] = '{1'b0, 1'b0, 3'b000, pk(0,1,0,1,0,0)};  // IDLE at least one cycle
    tbl[12] = '{1'b0, 1'b0, 3'b000, pk(1,1,0,1,0,1)};  // REQ
    tbl[13] = '{1'b0, 1'b1, 3'b000, pk(0,1,0,1,0,1)};  // WAIT
    tbl[14] = '{1'b0, 1'b1, 3'b101, pk(0,1,0,1,0,0)};  // 101 -> IDLE, floor/dir kept
    tbl[15] = '{1'b0, 1'b1, 3'b000, pk(0,1,0,1,0,0)};  // stays IDLE

    for (int i = 0; i < 16; i++)
      step(tbl[i].rst, tbl[i].q_empty, tbl[i].req, tbl[i].exp, $sformatf("vec%0d", i));

    // Trip 1 -> 4: 12 moving cycles, floor changes every 4 cycles, door 3 cycles.
    step(0, 0, 3'b000, pk(1,1,0,1,0,1), "up_req");
    step(0, 1, 3'b000, pk(0,1,0,1,0,1), "up_wait");
    step(0, 1, 3'b100, pk(0,1,1,1,0,1), "up_mv0");
    for (int k = 1; k < 12; k++)
      step(0, 1, 3'b000, pk(0, 1 + k/4, 1, 1, 0, 1), $sformatf("up_mv%0d", k));
    for (int k = 0; k < 3; k++)
      step(0, 1, 3'b000, pk(0,4,0,1,1,1), $sformatf("up_door%0d", k));
    step(0, 1, 3'b000, pk(0,4,0,1,0,0), "up_idle");

    // Trip 4 -> 2 with code 110: downward, 8 moving cycles.
    step(0, 0, 3'b000, pk(1,4,0,1,0,1), "dn_req");
    step(0, 1, 3'b000, pk(0,4,0,1,0,1), "dn_wait");
    step(0, 1, 3'b110, pk(0,4,1,0,0,1), "dn_mv0");
    for (int k = 1; k < 8; k++)
      step(0, 1, 3'b000, pk(0, 4 - k/4, 1, 0, 0, 1), $sformatf("dn_mv%0d", k));
    for (int k = 0; k < 3; k++)
      step(0, 1, 3'b000, pk(0,2,0,0,1,1), $sformatf("dn_door%0d", k));
    step(0, 1, 3'b000, pk(0,2,0,0,0,0), "dn_idle");

    // Reset while moving past floor 3 toward 4.
    step(0, 0, 3'b000, pk(1,2,0,0,0,1), "rm_req");
    step(0, 1, 3'b000, pk(0,2,0,0,0,1), "rm_wait");
    step(0, 1, 3'b100, pk(0,2,1,1,0,1), "rm_mv0");
    for (int k = 1; k < 6; k++)
      step(0, 1, 3'b000, pk(0, 2 + k/4, 1, 1, 0, 1), $sformatf("rm_mv%0d", k));
    step(1, 1, 3'b000, pk(0,1,0,1,0,0), "rm_rst0");
    step(1, 0, 3'b100, pk(0,1,0,1,0,0), "rm_rst1");

    // Empty buffer after reset: no done pulse over 20 cycles.
    for (int k = 0; k < 20; k++)
      step(0, 1, 3'b000, pk(0,1,0,1,0,0), $sformatf("quiet%0d", k));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
